// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular N:1 AXI-Stream arbiter with registered skid output
//
// Shares one downstream stream between PORTS upstream requesters. The grant is
// held for a whole frame, from the first beat through the tlast beat. Each new
// grant costs one arbitration cycle. Arbitration is round-robin or
// fixed-priority, where the lowest index wins.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   input_axis_*        PORTS packed upstream streams; port i uses slice i
//                       (tdata [i*DATA_WIDTH +: DATA_WIDTH], tkeep likewise)
//   output_axis_*       single muxed downstream stream (registered)
//   grant_valid         a port currently holds the frame grant
//   grant_encoded       index of the granted port, meaningful when grant_valid
//
// input_axis_tready depends only on registered state. There is no
// combinational path from output_axis_tready to any input ready.

module axis_frame_arbiter #(
  parameter int PORTS       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PORTS*DATA_WIDTH-1:0]                input_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]                input_axis_tkeep,
  input  logic [PORTS-1:0]                           input_axis_tvalid,
  output logic [PORTS-1:0]                           input_axis_tready,
  input  logic [PORTS-1:0]                           input_axis_tlast,
  input  logic [PORTS-1:0]                           input_axis_tuser,
  output logic [DATA_WIDTH-1:0]                      output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]                      output_axis_tkeep,
  output logic                                       output_axis_tvalid,
  input  logic                                       output_axis_tready,
  output logic                                       output_axis_tlast,
  output logic                                       output_axis_tuser,
  output logic                                       grant_valid,
  output logic [((PORTS > 2) ? $clog2(PORTS) : 1)-1:0] grant_encoded
);

  localparam int GW = (PORTS > 2) ? $clog2(PORTS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   grant_next;
  logic            grant_valid_reg;
  logic            grant_valid_next;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   last_grant_next;

  // Arbitration
  logic [2*PORTS-1:0] req_dbl;
  logic [2*PORTS-1:0] req_shift;
  logic [PORTS-1:0]   req_rot;
  int                 rot_amt;
  int                 pick_off;
  int                 pick_idx;
  logic               winner_found;
  logic [GW-1:0]      winner;

  // Granted-port mux
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_user;

  // Output register plus one skid entry
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [KEEP_WIDTH-1:0] out_keep_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic                  out_user_reg;
  logic [DATA_WIDTH-1:0] temp_data_reg;
  logic [KEEP_WIDTH-1:0] temp_keep_reg;
  logic                  temp_valid_reg;
  logic                  temp_last_reg;
  logic                  temp_user_reg;

  logic ready_int;
  logic accept;

  // Round-robin: rotate the request vector so that the bit just above
  // last_grant lands at position 0. The lowest set bit of the rotated vector
  // is then the winner. The previous winner ends up ranked last.
  always_comb begin
    rot_amt      = int'(last_grant) + 1;
    if (rot_amt >= PORTS) begin
      rot_amt = 0;
    end
    req_dbl      = {input_axis_tvalid, input_axis_tvalid};
    req_shift    = req_dbl >> rot_amt;
    req_rot      = req_shift[PORTS-1:0];
    pick_off     = 0;
    pick_idx     = 0;
    winner_found = 1'b0;
    winner       = '0;
    if (ROUND_ROBIN != 0) begin
      for (int j = PORTS - 1; j >= 0; j--) begin
        if (req_rot[j]) begin
          pick_off     = j;
          winner_found = 1'b1;
        end
      end
      pick_idx = rot_amt + pick_off;
      if (pick_idx >= PORTS) begin
        pick_idx = pick_idx - PORTS;
      end
    end else begin
      for (int j = PORTS - 1; j >= 0; j--) begin
        if (input_axis_tvalid[j]) begin
          pick_idx     = j;
          winner_found = 1'b1;
        end
      end
    end
    winner = GW'(pick_idx);
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_reg == GW'(i)) begin
        sel_data  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = input_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = input_axis_tvalid[i];
        sel_last  = input_axis_tlast[i];
        sel_user  = input_axis_tuser[i];
      end
    end
  end

  // Only the skid occupancy gates upstream readiness. One beat can still land
  // in the skid after the output stalls. After that, ready drops.
  assign ready_int = ~temp_valid_reg;
  assign accept    = (state == ACTIVE) & sel_valid & ready_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      last_grant      <= GW'(PORTS - 1);
    end else begin
      state           <= state_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      last_grant      <= last_grant_next;
    end
  end

  always_comb begin
    state_next        = state;
    grant_next        = grant_reg;
    grant_valid_next  = grant_valid_reg;
    last_grant_next   = last_grant;
    input_axis_tready = '0;
    case (state)
      IDLE: begin
        if (winner_found) begin
          grant_next       = winner;
          grant_valid_next = 1'b1;
          last_grant_next  = winner;
          state_next       = ACTIVE;
        end
      end
      ACTIVE: begin
        for (int i = 0; i < PORTS; i++) begin
          if (grant_reg == GW'(i)) begin
            input_axis_tready[i] = ready_int;
          end
        end
        if (accept && sel_last) begin
          grant_valid_next = 1'b0;
          state_next       = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A free output register takes the new beat, or drains the skid.
  // A stalled output sends the accepted beat into the skid instead.
  // accept and temp_valid_reg are mutually exclusive through ready_int.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_user_reg   <= 1'b0;
      temp_data_reg  <= '0;
      temp_keep_reg  <= '0;
      temp_valid_reg <= 1'b0;
      temp_last_reg  <= 1'b0;
      temp_user_reg  <= 1'b0;
    end else if (output_axis_tready || !out_valid_reg) begin
      if (accept) begin
        out_data_reg  <= sel_data;
        out_keep_reg  <= sel_keep;
        out_last_reg  <= sel_last;
        out_user_reg  <= sel_user;
        out_valid_reg <= 1'b1;
      end else if (temp_valid_reg) begin
        out_data_reg   <= temp_data_reg;
        out_keep_reg   <= temp_keep_reg;
        out_last_reg   <= temp_last_reg;
        out_user_reg   <= temp_user_reg;
        out_valid_reg  <= 1'b1;
        temp_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      temp_data_reg  <= sel_data;
      temp_keep_reg  <= sel_keep;
      temp_last_reg  <= sel_last;
      temp_user_reg  <= sel_user;
      temp_valid_reg <= 1'b1;
    end
  end

  assign output_axis_tdata  = out_data_reg;
  assign output_axis_tkeep  = out_keep_reg;
  assign output_axis_tvalid = out_valid_reg;
  assign output_axis_tlast  = out_last_reg;
  assign output_axis_tuser  = out_user_reg;
  assign grant_valid        = grant_valid_reg;
  assign grant_encoded      = grant_reg;

endmodule
